// File: rtl/led_ctrl.sv
// Memory-mapped LED controller: DATA/BLINK/PERIOD/CTRL window,
// per-LED blink on a shared half-period timebase, registered outputs.
module led_ctrl #(
    parameter int          N_LED      = 24,
    parameter logic [11:0] BASE_ADDR  = 12'h060,
    parameter int          PERIOD_W   = 32,
    parameter int unsigned PERIOD_RST = 50_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [11:0]      addr,
    input  logic             wen,
    input  logic [31:0]      wdata,
    input  logic             ren,
    output logic [31:0]      rdata,
    output logic [N_LED-1:0] led
);

    localparam logic [PERIOD_W-1:0] PERIOD_INIT = PERIOD_W'(PERIOD_RST);
    localparam logic [PERIOD_W-1:0] ONE         = PERIOD_W'(1);

    logic [N_LED-1:0]    data_q;
    logic [N_LED-1:0]    blink_q;
    logic [PERIOD_W-1:0] period_q;
    logic                en_q;
    logic                inv_q;
    logic [PERIOD_W-1:0] cnt_q;
    logic                ph_q;

    logic                hit;
    logic [1:0]          off;
    logic                wr_data;
    logic                wr_blink;
    logic                wr_period;
    logic                wr_ctrl;
    logic                blink_off;
    logic [N_LED-1:0]    raw;
    logic [N_LED-1:0]    led_d;
    logic [31:0]         rd_val;

    // Byte lanes and dropped write bits are intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{addr[1:0], wdata};

    always_comb begin
        hit       = (addr[11:4] == BASE_ADDR[11:4]);
        off       = addr[3:2];
        wr_data   = wen && hit && (off == 2'd0);
        wr_blink  = wen && hit && (off == 2'd1);
        wr_period = wen && hit && (off == 2'd2);
        wr_ctrl   = wen && hit && (off == 2'd3);
        blink_off = (period_q <= ONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q   <= '0;
            blink_q  <= '0;
            period_q <= PERIOD_INIT;
            en_q     <= 1'b1;
            inv_q    <= 1'b0;
        end else begin
            if (wr_data)   data_q   <= wdata[N_LED-1:0];
            if (wr_blink)  blink_q  <= wdata[N_LED-1:0];
            if (wr_period) period_q <= wdata[PERIOD_W-1:0];
            if (wr_ctrl) begin
                en_q  <= wdata[0];
                inv_q <= wdata[1];
            end
        end
    end

    // A PERIOD write restarts the phase in the on state.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            ph_q  <= 1'b1;
        end else if (wr_period || blink_off) begin
            cnt_q <= '0;
            ph_q  <= 1'b1;
        end else if (cnt_q == period_q - ONE) begin
            cnt_q <= '0;
            ph_q  <= ~ph_q;
        end else begin
            cnt_q <= cnt_q + ONE;
        end
    end

    always_comb begin
        raw   = data_q & (~blink_q | {N_LED{ph_q}});
        led_d = en_q ? (raw ^ {N_LED{inv_q}}) : '0;
    end

    always_comb begin
        rd_val = '0;
        if (hit) begin
            unique case (off)
                2'd0: rd_val[N_LED-1:0]    = data_q;
                2'd1: rd_val[N_LED-1:0]    = blink_q;
                2'd2: rd_val[PERIOD_W-1:0] = period_q;
                2'd3: rd_val[1:0]          = {inv_q, en_q};
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led   <= '0;
            rdata <= '0;
        end else begin
            led <= led_d;
            if (ren) rdata <= rd_val;
        end
    end

endmodule

// File: tb/tb_led_ctrl.sv
// Scoreboard bench for led_ctrl: stimulus queues expected led/rdata,
// a negedge monitor pops and compares.
module tb_led_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic        ren;
    logic [31:0] rdata;
    logic [23:0] led;

    led_ctrl #(
        .N_LED(24),
        .BASE_ADDR(12'h060),
        .PERIOD_W(32),
        .PERIOD_RST(50_000_000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .addr(addr),
        .wen(wen),
        .wdata(wdata),
        .ren(ren),
        .rdata(rdata),
        .led(led)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          c;
        logic [23:0] v;
        string       nm;
    } led_exp_t;

    typedef struct {
        logic [31:0] v;
        string       nm;
    } rd_exp_t;

    led_exp_t ledq[$];
    rd_exp_t  rdq[$];
    int       cyc = 0;
    logic     ren_d = 1'b0;
    int       checks = 0;
    int       errors = 0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        ren_d <= ren & ~rst;
    end

    always @(negedge clk) begin
        while (ledq.size() != 0 && ledq[0].c <= cyc) begin
            led_exp_t e;
            e = ledq.pop_front();
            checks++;
            if (e.c < cyc) begin
                errors++;
                $display("FAIL %s: missed led check at cycle %0d", e.nm, e.c);
            end else if (led !== e.v) begin
                errors++;
                $display("FAIL %s: led=%h expected %h (cycle %0d)",
                         e.nm, led, e.v, cyc);
            end
        end
        if (ren_d) begin
            checks++;
            if (rdq.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected: rdata=%h with no expectation", rdata);
            end else begin
                rd_exp_t r;
                r = rdq.pop_front();
                if (rdata !== r.v) begin
                    errors++;
                    $display("FAIL %s: rdata=%h expected %h", r.nm, rdata, r.v);
                end
            end
        end
    end

    task automatic op(input logic w, input logic r,
                      input logic [11:0] a, input logic [31:0] d);
        wen   = w;
        ren   = r;
        addr  = a;
        wdata = d;
        @(posedge clk);
        #1;
        wen = 1'b0;
        ren = 1'b0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        op(1'b1, 1'b0, a, d);
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] v,
                      input string nm);
        rd_exp_t r;
        r.v  = v;
        r.nm = nm;
        rdq.push_back(r);
        op(1'b0, 1'b1, a, 32'h0);
    endtask

    task automatic exp_led(input int c, input logic [23:0] v,
                           input string nm);
        led_exp_t e;
        e.c  = c;
        e.v  = v;
        e.nm = nm;
        ledq.push_back(e);
    endtask

    initial begin
        int c;
        int p;
        rst   = 1'b1;
        addr  = '0;
        wen   = 1'b0;
        wdata = '0;
        ren   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        exp_led(cyc, 24'h0, "rst_led");
        rd(12'h06C, 32'h1, "rst_ctrl");
        rd(12'h068, 32'd50_000_000, "rst_period");
        rd(12'h060, 32'h0, "rst_data");

        // Static pattern, upper bits dropped
        c = cyc;
        wr(12'h060, 32'hFFA5A5A5);
        exp_led(c + 2, 24'hA5A5A5, "data_led");
        rd(12'h060, 32'h00A5A5A5, "data_rd");

        // Blink with PERIOD=4
        wr(12'h064, 32'h0000000F);
        c = cyc;
        wr(12'h060, 32'h000000FF);
        exp_led(c + 2, 24'h0000FF, "blink_pre");
        p = cyc;
        wr(12'h068, 32'd4);
        for (int j = 2; j <= 17; j++)
            exp_led(p + j, (((j - 2) / 4) % 2 != 0) ? 24'h0000F0 : 24'h0000FF,
                    "blink");
        repeat (16) @(posedge clk);
        #1;

        // Invert, then disable
        wr(12'h064, 32'h0);
        wr(12'h060, 32'h1);
        c = cyc;
        wr(12'h06C, 32'h3);
        exp_led(c + 2, 24'hFFFFFE, "inv_led");
        c = cyc;
        wr(12'h06C, 32'h2);
        exp_led(c + 2, 24'h000000, "en0_led");
        rd(12'h06C, 32'h2, "ctrl_rd");

        // PERIOD=0 disables blinking
        wr(12'h068, 32'h0);
        wr(12'h064, 32'hFFFFFFFF);
        wr(12'h060, 32'h00123456);
        c = cyc;
        wr(12'h06C, 32'h1);
        for (int j = 2; j <= 101; j++)
            exp_led(c + j, 24'h123456, "p0_hold");
        repeat (101) @(posedge clk);
        #1;

        // Out-of-window access, ignored byte lanes
        c = cyc;
        wr(12'h070, 32'hDEADBEEF);
        exp_led(c + 2, 24'h123456, "miss_led");
        rd(12'h070, 32'h0, "miss_rd");
        rd(12'h060, 32'h00123456, "miss_data");
        rd(12'h064, 32'h00FFFFFF, "miss_blink");
        rd(12'h068, 32'h0, "miss_period");
        rd(12'h06F, 32'h1, "lane_ctrl");

        // Same-cycle read and write
        begin
            rd_exp_t r;
            r.v  = 32'h00123456;
            r.nm = "rw_old";
            rdq.push_back(r);
        end
        c = cyc;
        op(1'b1, 1'b1, 12'h060, 32'h00ABCDEF);
        exp_led(c + 2, 24'hABCDEF, "rw_led");
        rd(12'h060, 32'h00ABCDEF, "rw_new");

        // Reset during off phase
        wr(12'h064, 32'h000000FF);
        wr(12'h060, 32'h00FFFFFF);
        p = cyc;
        wr(12'h068, 32'd4);
        for (int j = 2; j <= 5; j++)
            exp_led(p + j, 24'hFFFFFF, "rb_on");
        exp_led(p + 6, 24'hFFFF00, "rb_off");
        exp_led(p + 7, 24'h000000, "rb_rst");
        exp_led(p + 8, 24'h000000, "rb_rst2");
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rd(12'h068, 32'd50_000_000, "rb_period");
        rd(12'h06C, 32'h1, "rb_ctrl");
        rd(12'h060, 32'h0, "rb_data");
        rd(12'h064, 32'h0, "rb_blink");

        for (int i = 0; i < 30 && (ledq.size() != 0 || rdq.size() != 0); i++)
            @(posedge clk);
        if (ledq.size() != 0 || rdq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d led and %0d rd expectations left",
                     ledq.size(), rdq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_ctrl.md
Name: led_ctrl

Overview:
- Memory-mapped LED controller; successor to the single-register 24-bit LED output port at 0x060.
- Adds a parametrised LED count, a 4-register window, per-LED blink with a programmable half-period, global enable/invert, and registered readback.
- Sits on the SoC peripheral bus next to the other I/O peripherals; `led` drives board pins.

Parameters:
- N_LED, 24, number of LED outputs (1..32).
- BASE_ADDR, 12'h060, byte base of the register window; must be 16-byte aligned.
- PERIOD_W, 32, width of the blink counter and PERIOD register (<=32).
- PERIOD_RST, 50_000_000, reset value of PERIOD (blink half-period in clk cycles).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- addr  in  12  bus byte address.
- wen  in  1  write strobe, one cycle per write.
- wdata  in  32  write data.
- ren  in  1  read strobe, one cycle per read.
- rdata  out  32  read data, valid the cycle after ren.
- led  out  N_LED  LED drive, registered.

Behaviour:
- Decode: hit = (addr[11:4] == BASE_ADDR[11:4]); offset = addr[3:2]; addr[1:0] ignored.
- Register map:
  - 0x0 DATA[N_LED-1:0]: static LED pattern.
  - 0x4 BLINK[N_LED-1:0]: per-LED blink mask.
  - 0x8 PERIOD[PERIOD_W-1:0]: blink half-period.
  - 0xC CTRL: bit0 EN, bit1 INV.
- Writes take wdata LSBs; upper bits are dropped. A write with wen=1 and hit updates the addressed register at that edge. Writes without hit are ignored.
- Reset values: DATA=0, BLINK=0, PERIOD=PERIOD_RST, CTRL.EN=1, CTRL.INV=0, cnt=0, ph=1, led=0, rdata=0.
- Blink timebase:
  - cnt (PERIOD_W bits) increments each cycle.
  - When cnt == PERIOD-1: cnt<=0 and ph<=~ph.
  - PERIOD==0 or PERIOD==1: cnt held 0 and ph held 1, so blinking LEDs stay on (blink disabled).
  - A write to PERIOD forces cnt<=0 and ph<=1 at the same edge, restarting the phase deterministically.
- Output function, registered each cycle:
  - raw_i = DATA_i & (~BLINK_i | ph).
  - If EN=1: led_i <= raw_i ^ INV. If EN=0: led <= 0, regardless of INV.
- Latency: a register write captured at edge T is reflected on `led` at edge T+1. A ph toggle at edge T is reflected on `led` at edge T+1.
- Read:
  - ren=1 with hit: rdata <= zero-extended addressed register at the next edge.
  - ren=1 without hit: rdata <= 0.
  - ren=0: rdata holds its last value.
  - CTRL reads as {30'b0, INV, EN}.
- Simultaneous ren and wen to the same register: rdata returns the pre-write value; the write still takes effect.
- rst asserted mid-blink or mid-access: everything returns to reset values at that edge and pending reads are dropped.
- There is no bus-error response; reads of unmapped addresses return 0.

Test Plan:
- Reset, then write DATA=32'hFFA5A5A5 at 0x060 -> led==24'hA5A5A5 one cycle after the write edge; a read of 0x060 returns 32'h00A5A5A5 one cycle after ren.
- PERIOD=4, BLINK=24'h00000F, DATA=24'h0000FF -> led[3:0] alternates F/0 every 4 cycles, first off-phase 4 cycles after the PERIOD write; led[7:4] stays F.
- CTRL=2'b11 (INV) with DATA=24'h000001 -> led==24'hFFFFFE; then CTRL=2'b10 (EN=0) -> led==0.
- PERIOD=0 with BLINK=all ones, DATA=24'h123456 -> led holds 24'h123456 for 100 cycles with no toggling.
- Write 0x070 (outside the window) with 32'hDEADBEEF -> no register changes; a read of 0x070 returns 0. Same-cycle ren+wen to 0x060 -> rdata shows the old DATA, and a later read shows the new value.
- Assert rst during blink with ph=0 -> next cycle led==0, PERIOD reads back PERIOD_RST, CTRL reads back 1.
